// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: bubble instruction, fetch state
// encoding, word type and the IF/ID bundle used by fetch, decode and hazard
// logic.
package mips_pkg;

  typedef logic [31:0] word_t;

  // sll $0,$0,0 encodes as all zeros; used wherever a bubble is injected
  localparam word_t NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    word_t instruction;
    word_t pc_plus4;
    logic  valid;
  } ifid_t;

  // An address can be fetched only if it is word aligned and inside the
  // populated instruction memory window [0, limit).
  function automatic logic isFetchable(input word_t addr, input word_t limit);
    return (addr < limit) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifid_register.sv
// Generic pipeline register holding an IF/ID style bundle.
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-high reset
//   flush_i          - replace contents with a bubble (highest priority)
//   hold_i           - keep current contents
//   load_i           - capture instruction_i / pcPlus4_i as a valid entry
//   instruction_i    - instruction word to capture
//   pcPlus4_i        - PC+4 of that instruction
//   instruction_o    - registered instruction
//   pcPlus4_o        - registered PC+4
//   valid_o          - registered valid flag
module ifid_register #(
  parameter logic [31:0] BUBBLE_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        load_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] pcPlus4_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pcPlus4_o,
  output logic        valid_o
);
  import mips_pkg::*;

  localparam ifid_t BUBBLE = '{instruction: BUBBLE_WORD, pc_plus4: 32'h0, valid: 1'b0};

  ifid_t ifid_q;

  // Priority is reset > flush > hold > load; with no control asserted the
  // register simply keeps its value.
  always_ff @(posedge clock) begin
    if (reset) begin
      ifid_q <= BUBBLE;
    end else if (flush_i) begin
      ifid_q <= BUBBLE;
    end else if (hold_i) begin
      ifid_q <= ifid_q;
    end else if (load_i) begin
      ifid_q <= '{instruction: instruction_i, pc_plus4: pcPlus4_i, valid: 1'b1};
    end
  end

  assign instruction_o = ifid_q.instruction;
  assign pcPlus4_o     = ifid_q.pc_plus4;
  assign valid_o       = ifid_q.valid;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch stage sequencer for the 5-stage MIPS pipeline. Owns the
// PC, drives the zero-latency instruction memory address, owns the IF/ID
// register, applies stalls and branch redirects, and halts when the PC leaves
// the populated instruction memory window.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   stall             - hazard unit hold request
//   branch_taken      - redirect request from branch resolution
//   branch_target     - redirect byte address
//   imem_addr         - instruction memory address (equals pc)
//   imem_instruction  - instruction word read at imem_addr this cycle
//   pc                - current PC register
//   ifid_instruction  - IF/ID instruction
//   ifid_pc_plus4     - IF/ID PC+4
//   ifid_valid        - IF/ID holds a real fetched instruction
//   halted            - fetch is halted (lags the HALT transition by a cycle)
//   fetch_count       - saturating count of instructions delivered to IF/ID
module fetch_controller #(
  parameter int unsigned IMEM_BYTES = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_instruction,
  output logic [31:0]          pc,
  output logic [31:0]          ifid_instruction,
  output logic [31:0]          ifid_pc_plus4,
  output logic                 ifid_valid,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] fetch_count
);
  import mips_pkg::*;

  localparam word_t IMEM_LIMIT = 32'(IMEM_BYTES);

  fetch_state_e          state_q, state_d;
  word_t                 pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  fetchCount_q, fetchCount_d;
  logic                  halted_q;
  logic                  ifidFlush, ifidHold, ifidLoad;
  logic                  pcFetchable, targetFetchable;
  word_t                 pcPlus4;

  assign pcFetchable     = isFetchable(pc_q, IMEM_LIMIT);
  assign targetFetchable = isFetchable(branch_target, IMEM_LIMIT);
  assign pcPlus4         = pc_q + 32'd4;

  // Next-state decision for PC, fetch state, counter and IF/ID controls.
  // A branch always flushes IF/ID and wins over a stall; a bad target still
  // lands in the PC so the faulting address stays visible for debug.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetchCount_d = fetchCount_q;
    ifidFlush    = 1'b0;
    ifidHold     = 1'b0;
    ifidLoad     = 1'b0;
    case (state_q)
      FETCH_RUN: begin
        if (branch_taken) begin
          pc_d      = branch_target;
          ifidFlush = 1'b1;
          if (!targetFetchable) begin
            state_d = FETCH_HALT;
          end
        end else if (stall) begin
          ifidHold = 1'b1;
        end else if (!pcFetchable) begin
          ifidFlush = 1'b1;
          state_d   = FETCH_HALT;
        end else begin
          ifidLoad = 1'b1;
          pc_d     = pcPlus4;
          if (fetchCount_q != '1) begin
            fetchCount_d = fetchCount_q + 1'b1;
          end
        end
      end
      FETCH_HALT: begin
        ifidFlush = 1'b1;
        if (branch_taken) begin
          pc_d = branch_target;
          if (targetFetchable) begin
            state_d = FETCH_RUN;
          end
        end
      end
      default: begin
        state_d   = FETCH_HALT;
        ifidFlush = 1'b1;
      end
    endcase
  end

  // Fetch state machine registers. halted follows the state register one
  // cycle later, so it reports HALT on the cycle after the transition edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FETCH_RUN;
      pc_q         <= RESET_PC;
      fetchCount_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetchCount_q <= fetchCount_d;
      halted_q     <= (state_q == FETCH_HALT);
    end
  end

  ifid_register #(
    .BUBBLE_WORD (NOP_WORD)
  ) ifidReg (
    .clock         (clock),
    .reset         (reset),
    .flush_i       (ifidFlush),
    .hold_i        (ifidHold),
    .load_i        (ifidLoad),
    .instruction_i (imem_instruction),
    .pcPlus4_i     (pcPlus4),
    .instruction_o (ifid_instruction),
    .pcPlus4_o     (ifid_pc_plus4),
    .valid_o       (ifid_valid)
  );

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: a cycle-level behavioural model
// of the fetch rules is compared against the DUT on every falling edge, and
// directed sequences add literal expectations at key points.
module tb_fetch_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic [31:0] pc;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  logic [31:0] mem [16];

  // Behavioural model state
  logic [31:0] mPc, mInstr, mPc4;
  logic        mValid, mHaltState, mHalted;
  logic [15:0] mCount;

  fetch_controller #(
    .IMEM_BYTES (64),
    .RESET_PC   (32'h0),
    .NOP_WORD   (32'h0),
    .CNT_WIDTH  (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .pc               (pc),
    .ifid_instruction (ifid_instruction),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_valid       (ifid_valid),
    .halted           (halted),
    .fetch_count      (fetch_count)
  );

  always #5 clock = ~clock;

  // Zero-latency instruction memory; out-of-window reads return a marker
  assign imem_instruction = (imem_addr < 32'd64 && imem_addr[1:0] == 2'b00)
                            ? mem[imem_addr[5:2]] : 32'hDEAD_BEEF;

  function automatic bit fetchable(input logic [31:0] a);
    return (a < 32'd64) && (a % 32'd4 == 32'd0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h at t=%0t", name, actual, required, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [31:0] t);
    reset         = r;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    @(negedge clock);
    #1;
  endtask

  // Model: what each rising edge must do, written from the fetch rules
  always @(posedge clock) begin : model
    logic [31:0] word;
    bit wasHalt;
    word    = fetchable(mPc) ? mem[mPc[5:2]] : 32'hDEAD_BEEF;
    wasHalt = mHaltState;
    if (reset) begin
      mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
      mHaltState = 1'b0; mHalted = 1'b0; mCount = 16'h0;
    end else begin
      if (mHaltState || branch_taken) begin
        if (branch_taken) begin
          mPc        = branch_target;
          mHaltState = !fetchable(branch_target);
        end
        mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
      end else if (stall) begin
        // everything held
      end else if (!fetchable(mPc)) begin
        mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
        mHaltState = 1'b1;
      end else begin
        mInstr = word; mPc4 = mPc + 32'd4; mValid = 1'b1;
        mPc    = mPc + 32'd4;
        if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
      end
      mHalted = wasHalt;
    end
  end

  // Compare process: DUT against model on every falling edge
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("pc", pc, mPc);
      checkOutput("imem_addr", imem_addr, mPc);
      checkOutput("ifid_instruction", ifid_instruction, mInstr);
      checkOutput("ifid_pc_plus4", ifid_pc_plus4, mPc4);
      checkOutput("ifid_valid", {31'h0, ifid_valid}, {31'h0, mValid});
      checkOutput("halted", {31'h0, halted}, {31'h0, mHalted});
      checkOutput("fetch_count", {16'h0, fetch_count}, {16'h0, mCount});
    end
  end

  initial begin
    logic [31:0] words [4];
    words[0] = 32'h0109_8020;
    words[1] = 32'h020A_8822;
    words[2] = 32'h0211_9020;
    words[3] = 32'h0251_9820;
    for (int i = 0; i < 16; i++) mem[i] = 32'h2000_0000 | i;
    for (int i = 0; i < 4; i++) mem[i] = words[i];

    // Reset state
    applyStimulus(1, 0, 0, 0);
    checkEn = 1'b1;
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset valid", {31'h0, ifid_valid}, 32'h0);
    checkOutput("reset instr", ifid_instruction, 32'h0);
    checkOutput("reset count", {16'h0, fetch_count}, 32'h0);
    checkOutput("reset halted", {31'h0, halted}, 32'h0);

    // Straight-line fetch of four words
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("run instr", ifid_instruction, words[i]);
      checkOutput("run pc4", ifid_pc_plus4, 32'(4 * (i + 1)));
      checkOutput("run valid", {31'h0, ifid_valid}, 32'h1);
    end
    checkOutput("run count", {16'h0, fetch_count}, 32'd4);
    checkOutput("model run count", {16'h0, mCount}, 32'd4);
    checkOutput("run pc", pc, 32'd16);

    // Stall for three cycles at pc=8
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("stall pc", pc, 32'd8);
      checkOutput("stall instr", ifid_instruction, 32'h020A_8822);
      checkOutput("stall pc4", ifid_pc_plus4, 32'd8);
      checkOutput("stall count", {16'h0, fetch_count}, 32'd2);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("unstall instr", ifid_instruction, 32'h0211_9020);
    checkOutput("unstall pc4", ifid_pc_plus4, 32'd12);

    // Branch wins over simultaneous stall
    applyStimulus(0, 1, 1, 32'd4);
    checkOutput("branch pc", pc, 32'd4);
    checkOutput("branch valid", {31'h0, ifid_valid}, 32'h0);
    checkOutput("branch instr", ifid_instruction, 32'h0);
    checkOutput("model branch pc", mPc, 32'd4);
    applyStimulus(0, 0, 0, 0);
    checkOutput("post-branch instr", ifid_instruction, 32'h020A_8822);
    checkOutput("post-branch pc4", ifid_pc_plus4, 32'd8);

    // Run off the end of the window
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("end pc", pc, 32'd64);
    checkOutput("end count", {16'h0, fetch_count}, 32'd18);
    applyStimulus(0, 0, 0, 0);
    checkOutput("halt-edge valid", {31'h0, ifid_valid}, 32'h0);
    checkOutput("halt-edge halted", {31'h0, halted}, 32'h0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("halted flag", {31'h0, halted}, 32'h1);
    checkOutput("halted pc", pc, 32'd64);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, logic'(i % 2 == 0), 0, 0);
      checkOutput("halt stall pc", pc, 32'd64);
      checkOutput("halt stall valid", {31'h0, ifid_valid}, 32'h0);
    end
    applyStimulus(0, 0, 1, 32'd0);
    checkOutput("resume pc", pc, 32'd0);
    checkOutput("resume valid", {31'h0, ifid_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("resume instr", ifid_instruction, 32'h0109_8020);
    checkOutput("resume valid2", {31'h0, ifid_valid}, 32'h1);
    checkOutput("resume halted", {31'h0, halted}, 32'h0);

    // Misaligned and out-of-range targets
    applyStimulus(0, 0, 1, 32'd6);
    checkOutput("misalign pc", pc, 32'd6);
    applyStimulus(0, 0, 0, 0);
    checkOutput("misalign halted", {31'h0, halted}, 32'h1);
    checkOutput("misalign valid", {31'h0, ifid_valid}, 32'h0);
    applyStimulus(0, 0, 1, 32'd0);
    applyStimulus(0, 0, 1, 32'd68);
    checkOutput("oor pc", pc, 32'd68);
    applyStimulus(0, 0, 0, 0);
    checkOutput("oor halted", {31'h0, halted}, 32'h1);
    checkOutput("oor valid", {31'h0, ifid_valid}, 32'h0);

    // Reset dominates stall and branch
    applyStimulus(0, 0, 1, 32'd0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pre-reset pc", pc, 32'd8);
    applyStimulus(1, 1, 1, 32'd20);
    checkOutput("mid reset pc", pc, 32'd0);
    checkOutput("mid reset valid", {31'h0, ifid_valid}, 32'h0);
    checkOutput("mid reset halted", {31'h0, halted}, 32'h0);
    checkOutput("mid reset count", {16'h0, fetch_count}, 32'h0);

    // Counter saturation
    reset = 1'b0;
    stall = 1'b1;
    branch_taken = 1'b0;
    force dut.fetchCount_q = 16'hFFFE;
    #1;
    release dut.fetchCount_q;
    mCount = 16'hFFFE;
    applyStimulus(0, 1, 0, 0);
    checkOutput("sat preload", {16'h0, fetch_count}, 32'h0000_FFFE);
    applyStimulus(0, 0, 0, 0);
    checkOutput("sat first", {16'h0, fetch_count}, 32'h0000_FFFF);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("sat final", {16'h0, fetch_count}, 32'h0000_FFFF);
    checkOutput("model sat", {16'h0, mCount}, 32'h0000_FFFF);

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
